mdu_iter: RTL and testbench

MDU_ITER -- requirements
Module: mdu_iter

---
 rtl/mdu_pkg.sv | 41 ++++
 rtl/mdu_step.sv | 37 +++
 rtl/mdu_iter.sv | 182 ++++++++++++++++++
 tb/tb_mdu_iter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared types for the iterative multiply/divide unit: op encodings, FSM states
// and the legal XLEN/STEP values.
package mdu_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } mdu_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } mdu_state_e;

  localparam int unsigned XLEN_32 = 32;
  localparam int unsigned XLEN_64 = 64;
  localparam int unsigned STEP_1  = 1;
  localparam int unsigned STEP_2  = 2;
  localparam int unsigned STEP_4  = 4;

  function automatic logic op_is_div(input mdu_op_e op);
    return op inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
  endfunction

  function automatic logic op_a_signed(input mdu_op_e op);
    return op inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM};
  endfunction

  function automatic logic op_b_signed(input mdu_op_e op);
    return op inside {OP_MULH, OP_DIV, OP_REM};
  endfunction

endpackage

// File: rtl/mdu_step.sv
// One STEP-bit iteration of shift-add multiply or restoring divide on the
// shared {hi[XLEN:0], lo[XLEN-1:0]} accumulator.
module mdu_step
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 1
) (
  input  logic              i_div,
  input  logic [2*XLEN:0]   i_acc,
  input  logic [XLEN-1:0]   i_opd,
  output logic [2*XLEN:0]   o_acc
);

  logic [2*XLEN:0] w_acc;
  logic [XLEN:0]   w_hi;

  // Multiply: add multiplicand on lsb then shift right; divide: shift left then trial-subtract.
  always_comb begin
    w_acc = i_acc;
    w_hi  = '0;
    for (int k = 0; k < int'(STEP); k++) begin
      if (i_div) begin
        w_acc = {w_acc[2*XLEN-1:0], 1'b0};
        if (w_acc[2*XLEN:XLEN] >= {1'b0, i_opd}) begin
          w_hi  = w_acc[2*XLEN:XLEN] - {1'b0, i_opd};
          w_acc = {w_hi, w_acc[XLEN-1:1], 1'b1};
        end
      end else begin
        w_hi  = w_acc[2*XLEN:XLEN] + (w_acc[0] ? {1'b0, i_opd} : {(XLEN+1){1'b0}});
        w_acc = {1'b0, w_hi, w_acc[XLEN-1:1]};
      end
    end
    o_acc = w_acc;
  end

endmodule

// File: rtl/mdu_iter.sv
// Iterative RISC-V M-extension multiply/divide unit, STEP bits per cycle.
// Define MDU_EARLY_OUT_EN to retire trivial cases (x/0, overflow, x/1, mul by 0) in one cycle.
module mdu_iter
  import mdu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned STEP = 1,
  parameter int unsigned TAGW = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      m_op,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [TAGW-1:0] rd_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [TAGW-1:0] rd_out,
  output logic            busy
);

  localparam int unsigned NITER = XLEN / STEP;
  localparam int unsigned CNTW  = $clog2(NITER + 1);

  mdu_state_e      r_state;
  mdu_op_e         r_op;
  logic [TAGW-1:0] r_rd;
  logic [TAGW-1:0] r_rd_out;
  logic [2*XLEN:0] r_acc;
  logic [XLEN-1:0] r_opd;
  logic [CNTW-1:0] r_cnt;
  logic            r_sa;
  logic            r_sb;
  logic            r_bz;
  logic [XLEN-1:0] r_result;
  logic            r_out_valid;
  logic            r_busy;

  mdu_op_e         w_op;
  logic            w_sa;
  logic            w_sb;
  logic [XLEN-1:0] w_abs_a;
  logic [XLEN-1:0] w_abs_b;
  logic            w_accept;
  logic [2*XLEN:0] w_acc_nxt;
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0] w_quo;
  logic [XLEN-1:0] w_rem;
  logic [XLEN-1:0] w_fix;

  assign w_op     = mdu_op_e'(m_op);
  assign w_sa     = op_a_signed(w_op) & op_a[XLEN-1];
  assign w_sb     = op_b_signed(w_op) & op_b[XLEN-1];
  assign w_abs_a  = w_sa ? -op_a : op_a;
  assign w_abs_b  = w_sb ? -op_b : op_b;
  assign in_ready = (r_state == S_IDLE) && !flush;
  assign w_accept = in_valid && in_ready;

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign rd_out    = r_rd_out;
  assign busy      = r_busy;

  mdu_step #(.XLEN(XLEN), .STEP(STEP)) u_step (
    .i_div (op_is_div(r_op)),
    .i_acc (r_acc),
    .i_opd (r_opd),
    .o_acc (w_acc_nxt)
  );

  // Sign correction: quotient/product take sa^sb, remainder follows the dividend.
  assign w_prod = (r_sa ^ r_sb) ? -r_acc[2*XLEN-1:0] : r_acc[2*XLEN-1:0];
  assign w_quo  = (r_sa ^ r_sb) ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
  assign w_rem  = r_sa ? -r_acc[2*XLEN-1:XLEN] : r_acc[2*XLEN-1:XLEN];

  always_comb begin
    w_fix = '0;
    unique case (r_op)
      OP_MUL:                     w_fix = w_prod[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_fix = w_prod[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:            w_fix = r_bz ? '1 : w_quo;
      default:                    w_fix = w_rem;
    endcase
  end

`ifdef MDU_EARLY_OUT_EN
  logic            w_ovf;
  logic            w_early;
  logic [XLEN-1:0] w_early_res;

  assign w_ovf = (w_op == OP_DIV || w_op == OP_REM) &&
                 (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);

  always_comb begin
    w_early     = 1'b0;
    w_early_res = '0;
    if (!op_is_div(w_op)) begin
      w_early = (op_a == '0) || (op_b == '0);
    end else if (op_b == '0) begin
      w_early     = 1'b1;
      w_early_res = (w_op == OP_DIV || w_op == OP_DIVU) ? '1 : op_a;
    end else if (w_ovf) begin
      w_early     = 1'b1;
      w_early_res = (w_op == OP_DIV) ? op_a : '0;
    end else if (op_b == XLEN'(1) && (w_op == OP_DIV || w_op == OP_DIVU)) begin
      w_early     = 1'b1;
      w_early_res = op_a;
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_op        <= OP_MUL;
      r_rd        <= '0;
      r_rd_out    <= '0;
      r_acc       <= '0;
      r_opd       <= '0;
      r_cnt       <= '0;
      r_sa        <= 1'b0;
      r_sb        <= 1'b0;
      r_bz        <= 1'b0;
      r_result    <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (flush) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_cnt       <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_op    <= w_op;
            r_rd    <= rd_in;
            r_sa    <= w_sa;
            r_sb    <= w_sb;
            r_bz    <= (op_b == '0);
            r_opd   <= op_is_div(w_op) ? w_abs_b : w_abs_a;
            r_acc   <= {{(XLEN+1){1'b0}}, (op_is_div(w_op) ? w_abs_a : w_abs_b)};
            r_cnt   <= CNTW'(NITER);
            r_busy  <= 1'b1;
            r_state <= S_CALC;
`ifdef MDU_EARLY_OUT_EN
            if (w_early) begin
              r_result    <= w_early_res;
              r_rd_out    <= rd_in;
              r_out_valid <= 1'b1;
              r_state     <= S_DONE;
            end
`endif
          end
        end
        S_CALC: begin
          r_acc <= w_acc_nxt;
          r_cnt <= r_cnt - CNTW'(1);
          if (r_cnt == CNTW'(1)) r_state <= S_FIX;
        end
        S_FIX: begin
          r_result    <= w_fix;
          r_rd_out    <= r_rd;
          r_out_valid <= 1'b1;
          r_state     <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mdu_iter.sv
// Directed bench for mdu_iter: a 32-bit/STEP=1 and a 64-bit/STEP=4 instance.
module tb_mdu_iter;
  import mdu_pkg::*;

`ifdef MDU_EARLY_OUT_EN
  localparam int OVF_LAT = 1;
`else
  localparam int OVF_LAT = 34;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush;
  logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_busy;
  logic [2:0] a_op;
  logic [31:0] a_a, a_b, a_res;
  logic [4:0] a_rd, a_rd_out;
  logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_busy;
  logic [2:0] b_op;
  logic [63:0] b_a, b_b, b_res;
  logic [4:0] b_rd, b_rd_out;

  int errors = 0;
  int checks = 0;

  mdu_iter #(.XLEN(32), .STEP(1), .TAGW(5)) u_d32 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .m_op(a_op), .op_a(a_a), .op_b(a_b), .rd_in(a_rd), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .result(a_res), .rd_out(a_rd_out), .busy(a_busy)
  );

  mdu_iter #(.XLEN(64), .STEP(4), .TAGW(5)) u_d64 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .m_op(b_op), .op_a(b_a), .op_b(b_b), .rd_in(b_rd), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .result(b_res), .rd_out(b_rd_out), .busy(b_busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic run32(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, output logic [31:0] res,
                       output logic [4:0] rdo, output int lat);
    @(negedge clk);
    chk("in_ready_idle32", 64'(a_in_ready), 64'd1);
    a_in_valid = 1'b1; a_op = op; a_a = a; a_b = b; a_rd = rd;
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!a_out_valid && lat < 100);
    chk("out_valid_seen32", 64'(a_out_valid), 64'd1);
    res = a_res;
    rdo = a_rd_out;
  endtask

  task automatic run64(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd, output logic [63:0] res,
                       output logic [4:0] rdo, output int lat);
    @(negedge clk);
    chk("in_ready_idle64", 64'(b_in_ready), 64'd1);
    b_in_valid = 1'b1; b_op = op; b_a = a; b_b = b; b_rd = rd;
    @(posedge clk);
    #1 b_in_valid = 1'b0;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!b_out_valid && lat < 100);
    chk("out_valid_seen64", 64'(b_out_valid), 64'd1);
    res = b_res;
    rdo = b_rd_out;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] r32;
    logic [63:0] r64;
    logic [4:0]  rdo;
    int          lat;
    logic        seen;

    rst = 1'b1; flush = 1'b0;
    a_in_valid = 1'b0; a_op = '0; a_a = '0; a_b = '0; a_rd = '0; a_out_ready = 1'b1;
    b_in_valid = 1'b0; b_op = '0; b_a = '0; b_b = '0; b_rd = '0; b_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 64'(a_out_valid), 64'd0);
    chk("rst_result", 64'(a_res), 64'd0);
    chk("rst_rd_out", 64'(a_rd_out), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    rst = 1'b0;

    run32(3'(OP_MUL), 32'd7, 32'hFFFF_FFFD, 5'd1, r32, rdo, lat);
    chk("mul_7x-3", 64'(r32), 64'h0000_0000_FFFF_FFEB);
    chk("mul_latency", 64'(lat), 64'd34);
    chk("mul_rd", 64'(rdo), 64'd1);

    run32(3'(OP_MULHU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, r32, rdo, lat);
    chk("mulhu_ff", 64'(r32), 64'h0000_0000_FFFF_FFFE);
    run32(3'(OP_MULH), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, r32, rdo, lat);
    chk("mulh_ff", 64'(r32), 64'd0);
    run32(3'(OP_MULHSU), 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, r32, rdo, lat);
    chk("mulhsu_ff", 64'(r32), 64'h0000_0000_FFFF_FFFF);

    run32(3'(OP_DIV), 32'hFFFF_FFF9, 32'd2, 5'd3, r32, rdo, lat);
    chk("div_-7/2", 64'(r32), 64'h0000_0000_FFFF_FFFD);
    run32(3'(OP_REM), 32'hFFFF_FFF9, 32'd2, 5'd3, r32, rdo, lat);
    chk("rem_-7/2", 64'(r32), 64'h0000_0000_FFFF_FFFF);
    run32(3'(OP_DIVU), 32'd7, 32'd0, 5'd3, r32, rdo, lat);
    chk("divu_7/0", 64'(r32), 64'h0000_0000_FFFF_FFFF);
    run32(3'(OP_REMU), 32'd7, 32'd0, 5'd3, r32, rdo, lat);
    chk("remu_7/0", 64'(r32), 64'd7);
    run32(3'(OP_DIV), 32'hFFFF_FFF9, 32'd0, 5'd3, r32, rdo, lat);
    chk("div_-7/0", 64'(r32), 64'h0000_0000_FFFF_FFFF);
    run32(3'(OP_REM), 32'hFFFF_FFF9, 32'd0, 5'd3, r32, rdo, lat);
    chk("rem_-7/0", 64'(r32), 64'h0000_0000_FFFF_FFF9);

    run32(3'(OP_DIV), 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, r32, rdo, lat);
    chk("div_ovf", 64'(r32), 64'h0000_0000_8000_0000);
    chk("div_ovf_latency", 64'(lat), 64'(OVF_LAT));
    run32(3'(OP_REM), 32'h8000_0000, 32'hFFFF_FFFF, 5'd4, r32, rdo, lat);
    chk("rem_ovf", 64'(r32), 64'd0);
    chk("rem_ovf_latency", 64'(lat), 64'(OVF_LAT));

    // Flush at the tenth CALC cycle
    @(negedge clk);
    a_in_valid = 1'b1; a_op = 3'(OP_DIV); a_a = 32'd1000; a_b = 32'd3; a_rd = 5'd9;
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      seen = seen | a_out_valid;
    end
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_in_ready", 64'(a_in_ready), 64'd1);
    chk("flush_busy", 64'(a_busy), 64'd0);
    repeat (40) begin
      @(negedge clk);
      seen = seen | a_out_valid;
    end
    chk("flush_no_out_valid", 64'(seen), 64'd0);

    run32(3'(OP_DIVU), 32'd100, 32'd7, 5'd5, r32, rdo, lat);
    chk("divu_100/7", 64'(r32), 64'd14);
    chk("divu_rd", 64'(rdo), 64'd5);

    // Flush and in_valid together: no acceptance
    @(negedge clk);
    flush = 1'b1; a_in_valid = 1'b1; a_op = 3'(OP_MUL); a_a = 32'd1; a_b = 32'd1;
    #1 chk("flush_in_ready_low", 64'(a_in_ready), 64'd0);
    @(posedge clk);
    #1 flush = 1'b0; a_in_valid = 1'b0;
    chk("flush_no_accept", 64'(a_busy), 64'd0);

    // Consumer stalls for 5 cycles in DONE while a new request waits
    a_out_ready = 1'b0;
    run32(3'(OP_MUL), 32'd6, 32'd7, 5'd3, r32, rdo, lat);
    chk("stall_mul", 64'(r32), 64'd42);
    a_in_valid = 1'b1; a_op = 3'(OP_MUL); a_a = 32'd1; a_b = 32'd1; a_rd = 5'd9;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", 64'(a_out_valid), 64'd1);
      chk("stall_result", 64'(a_res), 64'd42);
      chk("stall_rd", 64'(a_rd_out), 64'd3);
      chk("stall_in_ready", 64'(a_in_ready), 64'd0);
    end
    a_out_ready = 1'b1;
    @(posedge clk);
    #1 chk("done_exit_no_accept", 64'(a_busy), 64'd0);
    chk("done_exit_valid", 64'(a_out_valid), 64'd0);
    a_in_valid = 1'b0;

    // Reset mid-CALC wins over flush and in_valid
    @(negedge clk);
    a_in_valid = 1'b1; a_op = 3'(OP_MUL); a_a = 32'd5; a_b = 32'd5; a_rd = 5'd7;
    @(posedge clk);
    #1 a_in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b1; flush = 1'b1; a_in_valid = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0; flush = 1'b0; a_in_valid = 1'b0;
    chk("midcalc_rst_busy", 64'(a_busy), 64'd0);
    chk("midcalc_rst_result", 64'(a_res), 64'd0);
    chk("midcalc_rst_rd", 64'(a_rd_out), 64'd0);

    run64(3'(OP_MUL), 64'd3, 64'd5, 5'd4, r64, rdo, lat);
    chk("mul64_3x5", r64, 64'd15);
    chk("mul64_latency", 64'(lat), 64'd18);
    chk("mul64_rd", 64'(rdo), 64'd4);
    run64(3'(OP_DIVU), 64'd1000, 64'd7, 5'd6, r64, rdo, lat);
    chk("divu64_1000/7", r64, 64'd142);
    run64(3'(OP_REM), 64'hFFFF_FFFF_FFFF_FC18, 64'd7, 5'd6, r64, rdo, lat);
    chk("rem64_-1000/7", r64, 64'hFFFF_FFFF_FFFF_FFFA);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
